// File: rtl/player_motion_pkg.sv
// Shared constants for the player sprite blocks.
// Holds the screen/sprite geometry and the motion state encoding, which the
// animation-select block will also decode.
package player_motion_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SPR_W    = 100;
  localparam int SPR_H    = 200;

  typedef enum logic [1:0] {
    GROUND  = 2'b00,
    RISING  = 2'b01,
    FALLING = 2'b10
  } motion_state_t;

endpackage

// File: rtl/player_motion_btn_sync.sv
// btn_sync: brings one raw push-button into the clk domain.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   din   - raw button, asynchronous to clk
//   level - synchronized button level
//   rise  - one-cycle pulse on a rising edge of the synchronized level
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;

endmodule

// File: rtl/player_motion.sv
// player_motion: per-frame sprite position from push buttons.
// Walks horizontally, runs a jump/gravity state machine, and clamps the
// sprite to the screen edges and the ground line.
// Ports:
//   clk          - system/pixel clock
//   rst          - synchronous active-high reset
//   frame_tick   - one-cycle pulse per frame (start of vblank)
//   btn_left     - raw left button
//   btn_right    - raw right button
//   btn_jump     - raw jump button
//   sprite_x     - sprite left edge (signed)
//   sprite_y     - sprite top edge (signed)
//   airborne     - high while RISING or FALLING
//   motion_state - 00 GROUND, 01 RISING, 10 FALLING
//
// state   | meaning
// --------+-----------------------------------------------
// GROUND  | standing on the ground line, jump may launch
// RISING  | airborne with upward (negative) velocity
// FALLING | airborne with zero or downward velocity
module player_motion
  import player_motion_pkg::*;
#(
  parameter int X_START = 270,
  parameter int STEP_X  = 4,
  parameter int JUMP_V  = 20,
  parameter int GRAVITY = 1,
  parameter int VMAX    = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               btn_jump,
  output logic signed [10:0] sprite_x,
  output logic signed [10:0] sprite_y,
  output logic               airborne,
  output logic [1:0]         motion_state
);

  localparam logic signed [11:0] GROUND_Y = 12'(SCREEN_H - SPR_H);
  localparam logic signed [11:0] X_MAX    = 12'(SCREEN_W - SPR_W);
  localparam logic signed [11:0] STEP     = 12'(STEP_X);
  localparam logic signed [10:0] X_RST    = 11'(X_START);
  localparam logic signed [7:0]  JUMP_VY  = 8'(-JUMP_V);
  localparam logic signed [8:0]  GRAV9    = 9'(GRAVITY);
  localparam logic signed [8:0]  VMAX9    = 9'(VMAX);

  logic left_lvl, right_lvl, jump_lvl;
  logic left_rise, right_rise, jump_rise;
  logic unused_sync;

  btn_sync u_sync_left (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_left),
    .level (left_lvl),
    .rise  (left_rise)
  );

  btn_sync u_sync_right (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_right),
    .level (right_lvl),
    .rise  (right_rise)
  );

  btn_sync u_sync_jump (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_jump),
    .level (jump_lvl),
    .rise  (jump_rise)
  );

  // Only the jump edge and the walk levels drive the motion logic.
  assign unused_sync = left_rise ^ right_rise ^ jump_lvl;

  motion_state_t     state_q, state_d;
  logic signed [10:0] x_q, x_d;
  logic signed [10:0] y_q, y_d;
  logic signed [7:0]  vy_q, vy_d;
  logic               jump_req_q;
  logic               jump_now;

  logic signed [11:0] x_sum;
  logic signed [11:0] y_sum;
  logic signed [8:0]  vy_inc;
  logic signed [7:0]  vy_next;

  // An edge arriving in the tick cycle itself still counts for that tick.
  assign jump_now = jump_req_q | jump_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      jump_req_q <= 1'b0;
    end else if (frame_tick) begin
      jump_req_q <= 1'b0;
    end else if (jump_rise) begin
      jump_req_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GROUND;
      x_q     <= X_RST;
      y_q     <= GROUND_Y[10:0];
      vy_q    <= '0;
    end else if (frame_tick) begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vy_q    <= vy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vy_d    = vy_q;
    x_sum   = $signed({x_q[10], x_q});

    case ({left_lvl, right_lvl})
      2'b10:   x_sum = $signed({x_q[10], x_q}) - STEP;
      2'b01:   x_sum = $signed({x_q[10], x_q}) + STEP;
      default: x_sum = $signed({x_q[10], x_q});
    endcase

    if (x_sum < 12'sd0) begin
      x_d = '0;
    end else if (x_sum > X_MAX) begin
      x_d = X_MAX[10:0];
    end else begin
      x_d = x_sum[10:0];
    end

    y_sum  = $signed({y_q[10], y_q}) + $signed({{4{vy_q[7]}}, vy_q});
    vy_inc = $signed({vy_q[7], vy_q}) + GRAV9;
    if (vy_inc > VMAX9) begin
      vy_next = VMAX9[7:0];
    end else begin
      vy_next = vy_inc[7:0];
    end

    case (state_q)
      GROUND: begin
        if (jump_now) begin
          vy_d    = JUMP_VY;
          state_d = RISING;
        end else begin
          y_d  = GROUND_Y[10:0];
          vy_d = '0;
        end
      end
      RISING, FALLING: begin
        if (y_sum >= GROUND_Y) begin
          y_d     = GROUND_Y[10:0];
          vy_d    = '0;
          state_d = GROUND;
        end else if (y_sum < 12'sd0) begin
          // Hit the top edge: stop dead and start falling.
          y_d     = '0;
          vy_d    = '0;
          state_d = FALLING;
        end else begin
          y_d     = y_sum[10:0];
          vy_d    = vy_next;
          state_d = vy_next[7] ? RISING : FALLING;
        end
      end
      default: begin
        y_d     = GROUND_Y[10:0];
        vy_d    = '0;
        state_d = GROUND;
      end
    endcase
  end

  assign sprite_x     = x_q;
  assign sprite_y     = y_q;
  assign airborne     = (state_q != GROUND);
  assign motion_state = state_q;

endmodule
